spi_master: RTL and testbench

- SPI master engine. Serialises one 32-bit word MSB-first on sdo and simultaneously captures 32 bits from sdi.
- Drives the same framing as the project's negedge-sampling SPI slave: CPOL=0, slave samples sdo and updates sdi on falling sck.
- Lets the FPGA initiate transfers (FPGA-to-FPGA link, or bench stimulus for the slave) instead of depending on the PIC as master.
- Sits between game-state logic (parallel word in and out) and the SPI pins.

---
 rtl/spi_master.sv | 125 ++++++++++++
 tb/tb_spi_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master, CPOL=0: shifts a 32-bit word out MSB-first on sdo and captures sdi on each rising sck.
// Start-to-done latency is 65*CLKDIV clk cycles. Start is ignored while busy, and no backpressure is applied.
module spi_master #(
  parameter int CLKDIV    = 4,
  parameter bit FRAME_RST = 1'b1
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        start,
  input  logic [31:0] d,
  input  logic        sdi,
  output logic        sck,
  output logic        sdo,
  output logic        spi_rst,
  output logic        busy,
  output logic        done,
  output logic [31:0] q
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_FIN} state_t;

  localparam logic [7:0] LAST    = 8'(CLKDIV - 1);
  localparam logic [7:0] PRELAST = 8'(CLKDIV - 2);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [4:0]  r_bit;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic [31:0] r_q;
  logic        r_sck;
  logic        r_sdo;
  logic        r_spi_rst;
  logic        r_busy;
  logic        r_done;

  assign sck     = r_sck;
  assign sdo     = r_sdo;
  assign spi_rst = r_spi_rst;
  assign busy    = r_busy;
  assign done    = r_done;
  assign q       = r_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_q       <= '0;
      r_sck     <= 1'b0;
      r_sdo     <= 1'b0;
      r_spi_rst <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tx      <= d;
            r_sdo     <= d[31];
            r_busy    <= 1'b1;
            r_sck     <= 1'b0;
            r_spi_rst <= FRAME_RST;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Release the slave resync one clk ahead of the first rising sck
          if (r_cnt == PRELAST) r_spi_rst <= 1'b0;
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_sck   <= 1'b1;
            r_rx    <= {r_rx[30:0], sdi};
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_HIGH: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_sck   <= 1'b0;
            r_state <= S_LOW;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_LOW: begin
          // sdo moves one clk after falling sck so the slave sees stable data
          if (r_cnt == 8'd0) begin
            r_sdo <= r_tx[30];
            r_tx  <= {r_tx[30:0], 1'b0};
          end
          // Last half period: FIN is its final clk, keeping latency at 65*CLKDIV
          if (r_bit == 5'd31 && r_cnt == PRELAST) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= S_FIN;
          end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_bit   <= r_bit + 5'd1;
            r_sck   <= 1'b1;
            r_rx    <= {r_rx[30:0], sdi};
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_FIN: begin
          r_q     <= r_rx;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural negedge-sampling slave.
module tb_spi_master;
  localparam int CLKDIV = 4;
  localparam int LAT    = 65 * CLKDIV;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        start = 1'b0;
  logic [31:0] d = '0;
  logic        sdi;
  logic        sck, sdo, spi_rst, busy, done;
  logic [31:0] q;

  always #5 clk = ~clk;

  spi_master #(.CLKDIV(CLKDIV), .FRAME_RST(1'b1)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .d(d), .sdi(sdi),
    .sck(sck), .sdo(sdo), .spi_rst(spi_rst), .busy(busy), .done(done), .q(q)
  );

  // Slave: resyncs on spi_rst, samples sdo and shifts sdi on falling sck
  logic [31:0] slave_word = '0;
  logic [31:0] s_tx = '0;
  logic [31:0] s_rx = '0;
  assign sdi = s_tx[31];
  always @(negedge sck or posedge spi_rst) begin
    if (spi_rst) begin
      s_tx <= slave_word;
      s_rx <= '0;
    end else begin
      s_rx <= {s_rx[30:0], sdo};
      s_tx <= {s_tx[30:0], 1'b0};
    end
  end

  int rises = 0;
  int falls = 0;
  always @(posedge sck) rises++;
  always @(negedge sck) falls++;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] dv;
    logic [31:0] sw;
    logic [31:0] expq;
    bit          glitch;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [31:0] dv, input logic [31:0] sw,
                           input logic [31:0] expq, input bit glitch, input string tag);
    int n, r0, f0, nbusy;
    bit got;
    slave_word = sw;
    d = dv;
    start = 1'b1;
    tick();
    start = 1'b0;
    d = ~dv;
    chk({tag, "_e0_busy"}, 32'(busy), 32'd1);
    chk({tag, "_e0_sdo"}, 32'(sdo), 32'(dv[31]));
    chk({tag, "_e0_spi_rst"}, 32'(spi_rst), 32'd1);
    r0 = rises;
    f0 = falls;
    nbusy = 0;
    got = 1'b0;
    n = 0;
    while (!got && n < LAT + 50) begin
      start = glitch && (n == 49 || n == 199);
      tick();
      n++;
      if (n == 2) chk({tag, "_spi_rst_e2"}, 32'(spi_rst), 32'd1);
      if (n == 3) begin
        chk({tag, "_spi_rst_e3"}, 32'(spi_rst), 32'd0);
        chk({tag, "_sck_e3"}, 32'(sck), 32'd0);
      end
      if (n == 4) chk({tag, "_sck_e4"}, 32'(sck), 32'd1);
      if (done) got = 1'b1;
      else if (!busy) nbusy++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    chk({tag, "_q"}, q, expq);
    chk({tag, "_sdo_bits"}, s_rx, dv);
    chk({tag, "_rises"}, 32'(rises - r0), 32'd32);
    chk({tag, "_falls"}, 32'(falls - f0), 32'd32);
    chk({tag, "_busy_gap"}, 32'(nbusy), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_sck"}, 32'(sck), 32'd0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < LAT + 50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int idle_bad, r0, n;

    vecs[0] = '{32'hA5C3_0F81, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0001, 32'h8000_0001, 32'h8000_0001, 1'b0};
    vecs[3] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};

    repeat (3) tick();
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_spi_rst", 32'(spi_rst), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", q, 32'd0);

    reset_b = 1'b1;
    r0 = rises;
    idle_bad = 0;
    repeat (100) begin
      tick();
      if (sck || sdo || busy || done || spi_rst) idle_bad++;
    end
    chk("idle_outputs", 32'(idle_bad), 32'd0);
    chk("idle_q", q, 32'd0);
    chk("idle_no_sck", 32'(rises - r0), 32'd0);

    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].dv, vecs[i].sw, vecs[i].expq, vecs[i].glitch, $sformatf("vec%0d", i));

    // Back-to-back frames with start held high throughout
    slave_word = 32'h1357_9BDF;
    d = 32'hFFFF_0000;
    start = 1'b1;
    tick();
    d = 32'h0000_FFFF;
    wait_done(n);
    chk("b2b_lat1", 32'(n), 32'(LAT));
    chk("b2b_sdo1", s_rx, 32'hFFFF_0000);
    chk("b2b_q1", q, 32'h1357_9BDF);
    slave_word = 32'h2468_ACE0;
    tick();
    chk("b2b_e0_busy", 32'(busy), 32'd1);
    chk("b2b_e0_done", 32'(done), 32'd0);
    chk("b2b_e0_spi_rst", 32'(spi_rst), 32'd1);
    start = 1'b0;
    wait_done(n);
    chk("b2b_lat2", 32'(n), 32'(LAT));
    chk("b2b_sdo2", s_rx, 32'h0000_FFFF);
    chk("b2b_q2", q, 32'h2468_ACE0);
    tick();

    // Reset in the middle of bit 12
    slave_word = 32'h5555_AAAA;
    d = 32'h8765_4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    chk("mid_sck_before", 32'(sck), 32'd1);
    reset_b = 1'b0;
    #1;
    chk("mid_rst_sck", 32'(sck), 32'd0);
    chk("mid_rst_sdo", 32'(sdo), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    tick();
    reset_b = 1'b1;
    tick();
    run_frame(32'h3C3C_C3C3, 32'h0F1E_2D3C, 32'h0F1E_2D3C, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
